// File: rtl/serial_mod5_pkg.sv
// Shared types and mod-5 arithmetic for the serial divisible-by-5 transmitter
// and its matching receiver.
package serial_mod5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    typedef logic [2:0] residue_t;

    localparam int CHECK_BITS = 3;

    // Residue of (2*r + b) mod 5; an illegal residue (5..7) is treated as 0.
    function automatic residue_t mod5_next(residue_t r, logic b);
        residue_t res;
        case (r)
            3'd0:    res = b ? 3'd1 : 3'd0;
            3'd1:    res = b ? 3'd3 : 3'd2;
            3'd2:    res = b ? 3'd0 : 3'd4;
            3'd3:    res = b ? 3'd2 : 3'd1;
            3'd4:    res = b ? 3'd4 : 3'd3;
            default: res = b ? 3'd1 : 3'd0;
        endcase
        return res;
    endfunction

    // Check value c = (2*r) mod 5, so that (value*8 + c) mod 5 == 0.
    function automatic logic [CHECK_BITS-1:0] mod5_check(residue_t r);
        logic [CHECK_BITS-1:0] c;
        case (r)
            3'd0:    c = 3'd0;
            3'd1:    c = 3'd2;
            3'd2:    c = 3'd4;
            3'd3:    c = 3'd1;
            3'd4:    c = 3'd3;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_mod5_residue.sv
// Running mod-5 residue of an MSB-first bit stream. Shared by the transmitter
// (to compute check bits) and the receiver (to test divisibility).
module serial_mod5_residue
    import serial_mod5_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_clear,
    input  logic     i_advance,
    input  logic     i_bit,
    output residue_t o_residue
);

    residue_t r_residue;

    // Residue register: reset/clear to 0, fold in one bit per advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_residue <= 3'd0;
        end else if (i_clear) begin
            r_residue <= 3'd0;
        end else if (i_advance) begin
            r_residue <= mod5_next(r_residue, i_bit);
        end else if (r_residue > 3'd4) begin
            r_residue <= 3'd0;
        end
    end

    assign o_residue = r_residue;

endmodule

// File: rtl/serial_mod5_check_tx.sv
// Serial transmitter: shifts a W-bit word out MSB-first, then appends three
// check bits that make the whole (W+3)-bit frame divisible by 5.
module serial_mod5_check_tx
    import serial_mod5_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_last
);

    localparam int CW = $clog2(W + CHECK_BITS);
    // Counter runs 0..W-1 over data beats and W..W+2 over check beats.
    localparam logic [CW-1:0] LAST_DATA = CW'(W - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(W + CHECK_BITS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [W-1:0]          r_shift;
    logic [CHECK_BITS-1:0] r_check;
    logic [CW-1:0]         r_count;
    residue_t              w_residue;
    residue_t              w_residue_next;
    logic                  w_accept;
    logic                  w_data_beat;

    assign w_accept       = (r_state == ST_IDLE) && in_valid;
    assign w_data_beat    = (r_state == ST_DATA) && out_ready;
    assign w_residue_next = mod5_next(w_residue, out_bit);

    serial_mod5_residue u_residue (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_advance (w_data_beat),
        .i_bit     (out_bit),
        .o_residue (w_residue)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/serial outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_bit      = 1'b0;
        out_last     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                out_valid = 1'b1;
                out_bit   = r_shift[W-1];
                if (out_ready && (r_count == LAST_DATA)) begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                out_valid = 1'b1;
                out_bit   = r_check[CHECK_BITS-1];
                out_last  = (r_count == LAST_BEAT);
                if (out_ready && (r_count == LAST_BEAT)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: load the word, shift data then check bits, count beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_check <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_count <= '0;
                    end
                end
                ST_DATA: begin
                    if (out_ready) begin
                        r_shift <= r_shift << 1;
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_DATA) begin
                            r_check <= mod5_check(w_residue_next);
                        end
                    end
                end
                ST_CHECK: begin
                    if (out_ready) begin
                        r_check <= r_check << 1;
                        r_count <= (r_count == LAST_BEAT) ? '0 : r_count + CW'(1);
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mod5_check_tx.sv
// Directed bench for serial_mod5_check_tx (W=16): table of words with
// hand-computed check bits, stall and reset sequences, and a random loopback
// whose receiver model tracks the stream residue bit by bit.
module tb_serial_mod5_check_tx;

    localparam int W     = 16;
    localparam int FRAME = W + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;

    int n_vec  = 0;
    int n_fail = 0;

    serial_mod5_check_tx #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d vectors, %0d miscompares)", n_vec, n_fail);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   chk;
        bit           noisy_valid;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one word and follow its frame. Stalls of stall_len cycles are
    // inserted before beats stall_a and stall_b (-1 disables). With
    // noisy_valid, in_valid stays high with other data during the frame.
    // Observed bits are returned for the loopback checks.
    task automatic send_frame(input logic [W-1:0] data, input logic [2:0] chk,
                              input bit chk_known, input int stall_a, input int stall_b,
                              input int stall_len, input bit noisy_valid,
                              output logic [FRAME-1:0] seen);
        logic [FRAME-1:0] exp_frame;
        logic             hold_bit;
        logic             hold_last;
        exp_frame = {data, chk};
        seen      = '0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        if (noisy_valid) begin
            in_data = ~data;
        end else begin
            in_valid = 1'b0;
            in_data  = '0;
        end
        for (int beat = 0; beat < FRAME; beat++) begin
            if (beat == stall_a || beat == stall_b) begin
                out_ready = 1'b0;
                hold_bit  = out_bit;
                hold_last = out_last;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_bit_hold", out_bit, hold_bit);
                    check("stall_last_hold", out_last, hold_last);
                end
                out_ready = 1'b1;
            end
            seen[FRAME-1-beat] = out_bit;
            check("beat_valid", out_valid, 1);
            check("beat_in_ready", in_ready, 0);
            check("beat_last", out_last, (beat == FRAME - 1) ? 1 : 0);
            if (chk_known) begin
                check("beat_bit", out_bit, exp_frame[FRAME-1-beat]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
    endtask

    logic [FRAME-1:0] ref_bits;
    logic [FRAME-1:0] got_bits;
    logic [W-1:0]     rnd;
    int               rx_res;

    initial begin
        // Words with hand-computed check bits: residue r -> c = 2r mod 5.
        vecs[0]  = '{16'h0000, 3'b000, 1'b0};
        vecs[1]  = '{16'h0001, 3'b010, 1'b0};  // r=1, stream 10
        vecs[2]  = '{16'h0007, 3'b100, 1'b0};  // r=2, stream 60
        vecs[3]  = '{16'hFFFF, 3'b000, 1'b1};  // 65535, r=0
        vecs[4]  = '{16'h0002, 3'b100, 1'b0};  // r=2
        vecs[5]  = '{16'h0003, 3'b001, 1'b0};  // r=3
        vecs[6]  = '{16'h0004, 3'b011, 1'b0};  // r=4
        vecs[7]  = '{16'h8000, 3'b001, 1'b0};  // 32768, r=3
        vecs[8]  = '{16'h00FE, 3'b011, 1'b1};  // 254, r=4
        vecs[9]  = '{16'h1234, 3'b000, 1'b0};  // 4660, r=0
        vecs[10] = '{16'h0006, 3'b010, 1'b0};  // r=1
        vecs[11] = '{16'h00FF, 3'b000, 1'b0};  // 255, r=0

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        rst = 1'b0;

        // Table-driven frames without stalls.
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].data, vecs[i].chk, 1'b1, -1, -1, 0, vecs[i].noisy_valid, got_bits);
        end

        // Stalls at beats 5 and 17 must not change the bit sequence.
        send_frame(16'h0007, 3'b100, 1'b1, -1, -1, 0, 1'b0, ref_bits);
        send_frame(16'h0007, 3'b100, 1'b1, 5, 17, 3, 1'b0, got_bits);
        check("stall_same_seq", got_bits, ref_bits);
        send_frame(16'h8000, 3'b001, 1'b1, 0, 18, 2, 1'b0, got_bits);

        // Reset at beat 8 aborts the frame; a new word then goes out cleanly.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_bit", out_bit, 0);
        check("abort_out_last", out_last, 0);
        send_frame(16'h0001, 3'b010, 1'b1, -1, -1, 0, 1'b0, got_bits);

        // Loopback: random words, receiver model folds each bit into a mod-5
        // residue and must see 0 once the last bit arrives.
        for (int n = 0; n < 100; n++) begin
            rnd = W'($urandom);
            send_frame(rnd, 3'b000, 1'b0, (n % 4 == 0) ? int'($urandom_range(0, FRAME - 1)) : -1,
                       -1, 2, 1'b0, got_bits);
            rx_res = 0;
            for (int b = FRAME - 1; b >= 0; b--) begin
                rx_res = (rx_res * 2 + int'(got_bits[b])) % 5;
            end
            check("loop_data", got_bits[FRAME-1:3], rnd);
            check("loop_div_by_5", rx_res, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
